// File: rtl/dcnn_mem_pkg.sv
// rtl/dcnn_mem_pkg.sv - shared types and default widths for the DCNN memory master
package dcnn_mem_pkg;

    localparam int DEF_ADDR_W = 17;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W  = 17;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        RD_DRAIN = 3'd2,
        WR       = 3'd3,
        WR_FLUSH = 3'd4,
        DONE     = 3'd5
    } state_t;

endpackage

// File: rtl/dcnn_sync_fifo.sv
// rtl/dcnn_sync_fifo.sv - first-word-fall-through read-return buffer with occupancy count
module dcnn_sync_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;

    // Pointers wrap explicitly so non-power-of-two depths also work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage array: contents are don't-care until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; push and pop together leave count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/dcnn_mem_master.sv
// rtl/dcnn_mem_master.sv - Avalon-MM block mover between on-chip RAM and DCNN streams
module dcnn_mem_master
    import dcnn_mem_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int LEN_W        = DEF_LEN_W,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [LEN_W-1:0]    cmd_len,
    output logic                done,
    output logic                src_valid,
    input  logic                src_ready,
    output logic [DATA_W-1:0]   src_data,
    input  logic                snk_valid,
    output logic                snk_ready,
    input  logic [DATA_W-1:0]   snk_data,
    output logic [ADDR_W-1:0]   avm_address,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic                avm_chipselect,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int CRD_W = CNT_W + 1;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_W-1:0]       addr;
    logic [LEN_W-1:0]        remaining;
    logic [CNT_W-1:0]        outstanding;
    logic [READ_LATENCY-1:0] rd_pipe;
    logic                    wr_busy;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_empty;
    logic                    cmd_fire;
    logic                    credit_ok;
    logic                    rd_accept;
    logic                    rd_return;
    logic                    wr_accept;
    logic                    snk_fire;
    logic                    src_pop;

    // Words already in the FIFO plus reads still in flight may never exceed the
    // FIFO depth, so every read return is guaranteed a free slot.
    assign credit_ok = (CRD_W'(fifo_count) + CRD_W'(outstanding)) < CRD_W'(FIFO_DEPTH);

    assign avm_read  = (state == RD) && (remaining != '0) && credit_ok;
    assign rd_accept = avm_read && !avm_waitrequest;
    assign rd_return = rd_pipe[READ_LATENCY-1];

    assign wr_accept = wr_busy && !avm_waitrequest;
    assign snk_ready = (state == WR) && (!wr_busy || !avm_waitrequest) && (remaining != '0);
    assign snk_fire  = snk_valid && snk_ready;

    assign src_valid = !fifo_empty;
    assign src_pop   = src_valid && src_ready;
    assign cmd_fire  = cmd_ready && cmd_valid;

    assign avm_write      = wr_busy;
    assign avm_writedata  = wr_data;
    assign avm_address    = wr_busy ? wr_addr : addr;
    assign avm_chipselect = avm_read | avm_write;
    assign avm_byteenable = '1;

    dcnn_sync_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_rd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_return),
        .push_data (avm_readdata),
        .pop       (src_pop),
        .pop_data  (src_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; drain exits on the final pop so done follows it directly.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        state_next = DONE;
                    end else if (cmd_write) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD: begin
                if (rd_accept && (remaining == LEN_W'(1))) begin
                    state_next = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if ((outstanding == '0) &&
                    (fifo_empty || ((fifo_count == CNT_W'(1)) && src_pop))) begin
                    state_next = DONE;
                end
            end
            WR: begin
                if (snk_fire && (remaining == LEN_W'(1))) begin
                    state_next = WR_FLUSH;
                end
            end
            WR_FLUSH: begin
                if (wr_accept) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Address/length bookkeeping: one word per accepted read or accepted sink beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr      <= '0;
            remaining <= '0;
        end else if (cmd_fire) begin
            addr      <= cmd_addr;
            remaining <= cmd_len;
        end else if (rd_accept || snk_fire) begin
            addr      <= addr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
        end
    end

    // Read latency pipe and in-flight count; a reset drops any returns still in the pipe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pipe     <= '0;
            outstanding <= '0;
        end else begin
            rd_pipe[0] <= rd_accept;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            outstanding <= outstanding + CNT_W'(rd_accept) - CNT_W'(rd_return);
        end
    end

    // One-entry write register; it refills in the same cycle the slave takes the old word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_busy <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (snk_fire) begin
            wr_busy <= 1'b1;
            wr_addr <= addr;
            wr_data <= snk_data;
        end else if (wr_accept) begin
            wr_busy <= 1'b0;
        end
    end

endmodule
